// File: rtl/tdc_pkg.sv
// Shared constants and types for the TDC host command path.
package tdc_pkg;

    localparam logic [7:0] FRAME_SYNC   = 8'hA5;
    localparam logic [7:0] CMD_RATE_DIV = 8'h01;
    localparam logic [7:0] CMD_ARM_MODE = 8'h02;
    localparam logic [7:0] CMD_LED_TEST = 8'h03;

    typedef enum logic [2:0] {
        PSync,
        PCmd,
        PDhi,
        PDlo,
        PChk
    } parse_state_e;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] d_hi,
                                             input logic [7:0] d_lo);
        return cmd ^ d_hi ^ d_lo;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling FSM, byte and stop-bit error strobes.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_100m,
    input  logic       rst_n,
    input  logic       uart_rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o,
    output logic       rx_idle_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} rx_state_e;

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;

    // Preset to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], uart_rx_i};
    end
    assign rx_s = sync_q[1];

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx_s) state_q <= StStart;
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            byte_valid_o <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            frame_err_o <= 1'b1;
                            state_q     <= StWaitHigh;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (rx_s) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign byte_o    = shift_q;
    assign rx_idle_o = (state_q == StIdle);

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: parses A5/CMD/D_HI/D_LO/CHK frames into a register-write strobe.
module uart_cmd_rx
    import tdc_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int unsigned TIMEOUT_CLKS = CLK_FREQ / 100
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        frame_err,
    output logic        chk_err,
    output logic        rx_busy
);

    localparam logic [19:0] ToLast = 20'(TIMEOUT_CLKS - 1);

    logic         byte_valid;
    logic [7:0]   rx_byte;
    logic         rx_idle;
    parse_state_e p_q;
    logic [7:0]   cmd_q;
    logic [7:0]   dhi_q;
    logic [7:0]   dlo_q;
    logic [19:0]  to_q;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk_100m    (clk_100m),
        .rst_n       (rst_n),
        .uart_rx_i   (uart_rx),
        .byte_valid_o(byte_valid),
        .byte_o      (rx_byte),
        .frame_err_o (frame_err),
        .rx_idle_o   (rx_idle)
    );

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= PSync;
            cmd_q     <= '0;
            dhi_q     <= '0;
            dlo_q     <= '0;
            to_q      <= '0;
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            chk_err   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            chk_err   <= 1'b0;

            // Inter-byte timer only advances while waiting for the next start bit.
            if (byte_valid || p_q == PSync) to_q <= '0;
            else if (rx_idle && to_q != ToLast) to_q <= to_q + 1'b1;

            if (frame_err) begin
                p_q <= PSync;
            end else if (byte_valid) begin
                unique case (p_q)
                    PSync: if (rx_byte == FRAME_SYNC) p_q <= PCmd;
                    PCmd: begin
                        cmd_q <= rx_byte;
                        p_q   <= PDhi;
                    end
                    PDhi: begin
                        dhi_q <= rx_byte;
                        p_q   <= PDlo;
                    end
                    PDlo: begin
                        dlo_q <= rx_byte;
                        p_q   <= PChk;
                    end
                    PChk: begin
                        if (rx_byte == frame_chk(cmd_q, dhi_q, dlo_q)) begin
                            cmd_valid <= 1'b1;
                            cmd_addr  <= cmd_q;
                            cmd_data  <= {dhi_q, dlo_q};
                        end else begin
                            chk_err <= 1'b1;
                        end
                        p_q <= PSync;
                    end
                    default: p_q <= PSync;
                endcase
            end else if (p_q != PSync && rx_idle && to_q == ToLast) begin
                p_q <= PSync;
            end
        end
    end

    assign rx_busy = !rx_idle || (p_q != PSync);

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
Host-to-board command path; the counterpart of the measurement UART transmitter. Receives 8N1 serial bytes on the FTDI RX line and validates 5-byte command frames. Emits a one-cycle register-write strobe (address plus 16-bit data), which the top level uses to configure the TDC (rate limit, arm mode, and similar settings). Sits beside the UART TX in the top level, on clk_100m.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115200, serial bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD (868, integer division), clocks per bit period
TIMEOUT_CLKS, CLK_FREQ/100 (1_000_000), inter-byte timeout; a partial frame is abandoned after this

Ports:
clk_100m  in  1  100 MHz system clock
rst_n  in  1  reset, asynchronous, active-low
uart_rx  in  1  raw serial input from FTDI; asynchronous, idle high
cmd_valid  out  1  one-cycle strobe: a valid frame was received
cmd_addr  out  8  command/register address from the last valid frame
cmd_data  out  16  data from the last valid frame, big-endian
frame_err  out  1  one-cycle pulse: stop bit sampled low
chk_err  out  1  one-cycle pulse: frame checksum mismatch
rx_busy  out  1  high while a byte is being received or a frame is partially parsed

Behaviour:
- Reset: all outputs 0. Both FSMs return to idle. Sync flops preset to 1 (line idle).
- Input synchronisation: uart_rx passes through a 2-FF synchroniser. All logic uses the synchronised value rx_s.
- Byte receiver states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START, bit counter cleared.
  - START: after CLKS_PER_BIT/2 clocks (434), sample rx_s. If 0 -> DATA. If 1 -> IDLE (glitch rejected, no error).
  - DATA: sample every CLKS_PER_BIT clocks, 8 samples, LSB first, shifted into the byte register. After the 8th sample -> STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - If 1: byte_valid pulses for one cycle, then -> IDLE.
    - If 0: frame_err pulses, the byte is discarded, then -> WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s==1, then -> IDLE. A break condition produces exactly one frame_err.
- Frame format: 0xA5, CMD, D_HI, D_LO, CHK, where CHK = CMD ^ D_HI ^ D_LO.
- Parser states: P_SYNC, P_CMD, P_DHI, P_DLO, P_CHK. Each byte_valid advances one state.
  - P_SYNC: advance only on byte 0xA5; all other bytes are ignored silently.
  - In the other states 0xA5 is ordinary data. A new frame does not restart mid-frame.
- At P_CHK:
  - Match: cmd_addr<=CMD and cmd_data<={D_HI,D_LO} in the same cycle that cmd_valid is asserted.
    - That cycle is the clock after the CHK byte_valid; latency is 1 cycle.
    - -> P_SYNC.
  - Mismatch: chk_err pulses, cmd_addr and cmd_data are unchanged, -> P_SYNC.
- cmd_addr and cmd_data hold their values until the next valid frame.
- Frame error while the parser is not in P_SYNC: the parser -> P_SYNC; the partial frame is dropped and chk_err is not asserted.
- Timeout: the timeout counter runs while the parser is not in P_SYNC and the receiver is in IDLE. It clears on every byte_valid. When it reaches TIMEOUT_CLKS, the parser -> P_SYNC silently.
- rx_busy = (receiver != IDLE) | (parser != P_SYNC).
- Back-to-back frames with no idle gap are accepted. The receiver re-arms in IDLE in the cycle after the stop-bit sample.
- Counters saturate rather than wrap. Bit-timing counters are sized from CLKS_PER_BIT; the timeout counter is 20 bits.

Decomposition:
- Shared package tdc_pkg holds:
  - FRAME_SYNC = 8'hA5
  - command address constants: CMD_RATE_DIV = 8'h01, CMD_ARM_MODE = 8'h02, CMD_LED_TEST = 8'h03
  - the parser state typedef
- One sub-module, uart_rx_byte, contains the synchroniser, the bit-level FSM, byte_valid, byte and frame_err.
- uart_cmd_rx instantiates uart_rx_byte and implements the frame parser and timeout.

Test Plan:
- Send A5 01 12 34 27 at 115200 -> one cmd_valid pulse with cmd_addr=0x01 and cmd_data=0x1234, 1 clock after the CHK stop-bit sample. No error pulses.
- Send A5 02 00 05 00 (checksum should be 07) -> chk_err pulses once. cmd_valid stays 0 and cmd_addr/cmd_data keep their previous values. A following valid frame is accepted.
- Send a 200-cycle low glitch on uart_rx -> no byte_valid, no frame_err, receiver returns to IDLE. Then send A5 03 00 01 02 -> cmd_valid with cmd_data=0x0001.
- Send byte 0x55 with its stop bit forced low, then hold the line low for 20 bit times -> exactly one frame_err. rx_busy stays high until the line returns high.
- Send A5 01, idle for 1.1*TIMEOUT_CLKS, then 12 34 27 -> no cmd_valid and no chk_err; the parser returns to P_SYNC before the 12 arrives. Then send the full frame A5 01 12 34 27 -> cmd_valid.
- Assert rst_n low midway through the D_HI byte, release, then send A5 01 AB CD 67 -> outputs read 0 after reset and the frame is accepted with cmd_data=0xABCD. Also send two frames back-to-back with no gap -> two cmd_valid pulses.
